// File: rtl/deserializer.sv
// deserializer
//   Collects serial bits qualified by write_in, assembles WIDTH-bit words
//   MSB-first and hands each word downstream with a ready/ack handshake.
//   status_out tells the serial source to stall while a word is pending.
//
// Ports
//   clock_100k  : sole clock, rising edge
//   reset       : synchronous, active-low
//   data_in     : serial data bit
//   write_in    : data_in valid this cycle
//   ack_in      : downstream has consumed data_out
//   data_out    : last completed word (held until the next word completes)
//   data_ready  : data_out holds an unacknowledged word
//   status_out  : busy; upstream must not assert write_in
//   overrun_out : sticky; a bit arrived while busy (cleared only by reset)
//
// state     | meaning
// ----------+---------------------------------------------------
// RECEIVING | shifting in bits, ack_in ignored
// WAIT_ACK  | word complete, waiting for ack_in; bits discarded

module deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock_100k,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             ack_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_ready,
  output logic             status_out,
  output logic             overrun_out
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    RECEIVING = 1'b0,
    WAIT_ACK  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] shift, shift_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             ready_nxt, status_nxt, overrun_nxt;

  always_ff @(posedge clock_100k) begin
    if (!reset) begin
      state       <= RECEIVING;
      count       <= '0;
      shift       <= '0;
      data_out    <= '0;
      data_ready  <= 1'b0;
      status_out  <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      shift       <= shift_nxt;
      data_out    <= data_nxt;
      data_ready  <= ready_nxt;
      status_out  <= status_nxt;
      overrun_out <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    shift_nxt   = shift;
    data_nxt    = data_out;
    ready_nxt   = data_ready;
    status_nxt  = status_out;
    overrun_nxt = overrun_out;

    case (state)
      RECEIVING: begin
        if (write_in) begin
          if (count == LAST_BIT) begin
            // Final bit goes straight into data_out on the same edge.
            data_nxt   = {shift[WIDTH-2:0], data_in};
            count_nxt  = '0;
            shift_nxt  = '0;
            ready_nxt  = 1'b1;
            status_nxt = 1'b1;
            state_nxt  = WAIT_ACK;
          end else begin
            shift_nxt = {shift[WIDTH-2:0], data_in};
            count_nxt = count + CW'(1);
          end
        end
      end

      WAIT_ACK: begin
        // A bit offered while busy is dropped, even alongside ack_in.
        if (write_in) begin
          overrun_nxt = 1'b1;
        end
        if (ack_in) begin
          ready_nxt  = 1'b0;
          status_nxt = 1'b0;
          state_nxt  = RECEIVING;
        end
      end

      default: begin
        state_nxt = RECEIVING;
      end
    endcase
  end

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer
//   Table-driven bench for deserializer (WIDTH=8). Each record holds the
//   inputs for one clock edge and the outputs expected just after it.

module tb_deserializer;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       ack_in;
  logic [7:0] data_out;
  logic       data_ready;
  logic       status_out;
  logic       overrun_out;

  int total_checks  = 0;
  int passed_checks = 0;

  deserializer #(.WIDTH(8)) dut (
    .clock_100k  (clk),
    .reset       (reset),
    .data_in     (data_in),
    .write_in    (write_in),
    .ack_in      (ack_in),
    .data_out    (data_out),
    .data_ready  (data_ready),
    .status_out  (status_out),
    .overrun_out (overrun_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         wr;
    bit         din;
    bit         ack;
    logic [7:0] e_do;
    bit         e_rdy;
    bit         e_st;
    bit         e_ov;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input bit wr, input bit din, input bit ack,
                              input logic [7:0] e_do, input bit e_rdy, input bit e_st,
                              input bit e_ov);
    vec_t v;
    v.rst = rst; v.wr = wr; v.din = din; v.ack = ack;
    v.e_do = e_do; v.e_rdy = e_rdy; v.e_st = e_st; v.e_ov = e_ov;
    vecs.push_back(v);
  endfunction

  // One word MSB-first, with 'gap' idle cycles between bits. Outputs keep
  // 'prev' until the eighth bit, which must land the word with ready/busy.
  function automatic void add_word(input logic [7:0] w, input int gap, input bit ack,
                                   input logic [7:0] prev, input bit ov);
    for (int i = 7; i >= 0; i--) begin
      if (i < 7) begin
        for (int g = 0; g < gap; g++) add(1'b1, 1'b0, 1'b0, ack, prev, 1'b0, 1'b0, ov);
      end
      if (i > 0) add(1'b1, 1'b1, w[i], ack, prev, 1'b0, 1'b0, ov);
      else       add(1'b1, 1'b1, w[i], ack, w,    1'b1, 1'b1, ov);
    end
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    else passed_checks++;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset    = v.rst;
    write_in = v.wr;
    data_in  = v.din;
    ack_in   = v.ack;
    @(posedge clk);
    #1;
    check({tag, " data_out"},    data_out,           v.e_do);
    check({tag, " data_ready"},  {7'd0, data_ready}, {7'd0, v.e_rdy});
    check({tag, " status_out"},  {7'd0, status_out}, {7'd0, v.e_st});
    check({tag, " overrun_out"}, {7'd0, overrun_out},{7'd0, v.e_ov});
  endtask

  initial begin
    vec_t       h;
    logic [7:0] w;
    bit         last;

    reset    = 1'b0;
    write_in = 1'b0;
    data_in  = 1'b0;
    ack_in   = 1'b0;

    // Reset with busy inputs for two edges.
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

    // Single word 0xA5, then ack for one cycle, then idle.
    add_word(8'hA5, 0, 1'b0, 8'h00, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);

    // Gapped 0x3C with ack_in high in the gaps (ignored while receiving).
    add_word(8'h3C, 3, 1'b1, 8'hA5, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);

    // Overrun: 0xFF, stray bit without ack, stray bit with ack, then 0x01.
    add_word(8'hFF, 0, 1'b0, 8'h3C, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    add_word(8'h01, 0, 1'b0, 8'hFF, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);

    // Reset mid-word: four 1s, reset, then 0x55 needs all eight bits.
    for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add_word(8'h55, 0, 1'b0, 8'h00, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);

    // ack_in tied high: 0x81, one-cycle gap, 0x7E; ready pulses one cycle.
    add_word(8'h81, 0, 1'b1, 8'h55, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    add_word(8'h7E, 0, 1'b1, 8'h81, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Hand sequence: 0xC3 without ack, ready must persist, then reset
    // while busy with write/ack asserted clears everything.
    w = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      last    = (i == 0);
      h.rst   = 1'b1; h.wr = 1'b1; h.din = w[i]; h.ack = 1'b0;
      h.e_do  = last ? 8'hC3 : 8'h7E;
      h.e_rdy = last; h.e_st = last; h.e_ov = 1'b0;
      apply(h, $sformatf("c3_bit%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      h.rst = 1'b1; h.wr = 1'b0; h.din = 1'b0; h.ack = 1'b0;
      h.e_do = 8'hC3; h.e_rdy = 1'b1; h.e_st = 1'b1; h.e_ov = 1'b0;
      apply(h, $sformatf("c3_hold%0d", i));
    end
    h.rst = 1'b0; h.wr = 1'b1; h.din = 1'b1; h.ack = 1'b1;
    h.e_do = 8'h00; h.e_rdy = 1'b0; h.e_st = 1'b0; h.e_ov = 1'b0;
    apply(h, "rst_busy");
    h.rst = 1'b1; h.wr = 1'b0; h.din = 1'b0; h.ack = 1'b0;
    apply(h, "rst_release");

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/deserializer.md
# deserializer

Serial-to-parallel converter clocked by the 100 kHz domain produced by the clock divider. Collects serial bits qualified by `write_in`, assembles WIDTH-bit words MSB-first, and presents each word to the downstream stage with a ready/acknowledge handshake. Asserts `status_out` while a word waits for consumption, telling the upstream serial source to stall.

## Interface
- WIDTH, 8, number of bits per assembled word (≥2)
- clock_100k  input  1  sole clock; all state changes on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clock_100k
- data_in  input  1  serial data bit
- write_in  input  1  data_in valid this cycle
- ack_in  input  1  downstream has consumed data_out
- data_out  output  WIDTH  last completed word
- data_ready  output  1  data_out holds an unacknowledged word
- status_out  output  1  busy; upstream must not assert write_in
- overrun_out  output  1  sticky; a bit arrived while busy

## Operation
- All outputs and internal state are registered.
- States:
  - RECEIVING: status_out=0, data_ready=0.
  - WAIT_ACK: status_out=1, data_ready=1.
- Internal: shift register `WIDTH` bits; bit counter `$clog2(WIDTH)` bits, 0..WIDTH-1.
- RECEIVING, write_in=1, counter<WIDTH-1:
  - shift left, data_in into LSB; counter+1.
- RECEIVING, write_in=1, counter==WIDTH-1:
  - data_out <= {shift[WIDTH-2:0], data_in}; counter <= 0; shift register cleared.
  - data_ready <= 1; status_out <= 1; go to WAIT_ACK.
- RECEIVING, write_in=0: hold everything. ack_in is ignored in RECEIVING.
- WAIT_ACK, ack_in=1: data_ready <= 0; status_out <= 0; go to RECEIVING. data_out is held unchanged.
- WAIT_ACK, write_in=1: bit discarded; overrun_out <= 1. Applies even if ack_in=1 in the same cycle; the bit is never captured.
- overrun_out clears only on reset.
- data_out retains its value until the next word completes; it never returns to zero except on reset.
- First bit received lands in data_out[WIDTH-1] (MSB-first).

## Timing
- Reset (reset==0 at a rising edge): state=RECEIVING, counter=0, shift=0, data_out=0, data_ready=0, status_out=0, overrun_out=0. Reset has priority over every other input.
- Reset mid-word discards partial bits; the next write_in after release is bit WIDTH-1.
- Word latency: data_out, data_ready and status_out update on the same edge that samples the WIDTH-th valid bit (0 extra cycles).
- ack_in is sampled on an edge; data_ready and status_out are low after that edge. A new bit may be accepted on the following edge.
- Minimum period per word: WIDTH+1 cycles (WIDTH bits plus 1 ack cycle).
- Gaps (write_in=0) between bits are allowed at any length; the counter does not time out.
- ack_in held high continuously: each word is acknowledged on the edge after completion; data_ready is high for exactly 1 cycle.

## Test plan
- Reset: hold reset=0 for 2 edges with random inputs -> all outputs 0, state RECEIVING.
- Single word: write_in=1 for 8 consecutive cycles with bits 1,0,1,0,0,1,0,1 -> data_out=0xA5, data_ready=1 and status_out=1 on the 8th edge; ack_in=1 for 1 cycle -> both low on the next edge; data_out stays 0xA5.
- Gapped input: send 0x3C with write_in=0 for 3 cycles between each bit -> data_out=0x3C, and data_ready asserts only after the 8th valid bit.
- Overrun: complete 0xFF, then assert write_in while data_ready=1 with no ack -> overrun_out=1 and stays 1; after ack, send 0x01 -> data_out=0x01 (the stray bit is not included).
- Reset mid-word: send 4 bits (1,1,1,1), pull reset=0 for 1 edge, then send 0x55 -> data_out=0x55, data_ready=1 after exactly 8 post-reset bits.
- Back-to-back with ack_in tied high: send 0x81 then 0x7E with a 1-cycle gap -> data_ready pulses 1 cycle per word, data_out=0x81 then 0x7E, overrun_out=0.
